// File: rtl/somador_sequencial.sv
`default_nettype none
// ============================================================================
// Module   : somador_sequencial
// Purpose  : Digit-serial adder/subtractor. Operands of WIDTH bits are
//            processed DIGIT bits per clock through a DIGIT-bit ripple-carry
//            slice, with the carry registered between digits. The result takes
//            N = WIDTH/DIGIT RUN cycles and is announced by a one-cycle done.
// Ports    : clock_i     - rising-edge clock
//            reset_i     - asynchronous active-high reset
//            start_i     - request a new operation (ignored while busy)
//            sub_i       - 0: a+b+cin, 1: a-b-cin (cin acts as borrow-in)
//            a_i, b_i    - operands, captured with start
//            cin_i       - carry/borrow in, captured with start
//            busy_o      - operation in progress
//            done_o      - one-cycle pulse, result newly valid
//            sum_o       - result modulo 2^WIDTH
//            cout_o      - carry out of the MSB (sub: 1 = no borrow)
//            overflow_o  - two's-complement signed overflow
// Revision : 1.0 - initial release
// ============================================================================
module somador_sequencial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             overflow_o
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;        // already inverted in subtract mode
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               ovf_q;
    logic               busy_q;
    logic               done_q;

    // Digit slice outputs
    logic [DIGIT-1:0]   slice_sum;
    logic               slice_cmsb;  // carry into the slice's top bit
    logic               slice_cout;  // carry out of the slice's top bit
    logic [WIDTH-1:0]   res_d;       // result with the current digit on top
    logic               last_digit;

    // Ripple-carry slice over the lowest digit of the shifting operands.
    always_comb begin
        logic c;
        c          = carry_q;
        slice_sum  = '0;
        slice_cmsb = 1'b0;
        for (int j = 0; j < DIGIT; j++) begin
            slice_sum[j] = a_q[j] ^ b_q[j] ^ c;
            if (j == DIGIT - 1) begin
                slice_cmsb = c;
            end
            c = (a_q[j] & b_q[j]) | (c & (a_q[j] ^ b_q[j]));
        end
        slice_cout = c;
    end

    assign last_digit = (cnt_q == CNT_W'(N - 1));

    // Result shift register: new digits enter at the top, so after N digits
    // digit 0 sits at the bottom. Only the WIDTH-DIGIT bits that survive to
    // the final cycle need storage; the newest digit comes straight from the
    // slice.
    generate
        if (N > 1) begin : g_res_shift
            logic [WIDTH-DIGIT-1:0] res_q;

            assign res_d = {slice_sum, res_q};

            always_ff @(posedge clock_i or posedge reset_i) begin
                if (reset_i) begin
                    res_q <= '0;
                end else if (state_q == RUN) begin
                    res_q <= res_d[WIDTH-1:DIGIT];
                end
            end
        end else begin : g_res_single
            assign res_d = slice_sum;
        end
    endgenerate

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        // Subtraction as a + ~b + ~cin: borrow-in becomes an
                        // inverted carry-in.
                        a_q     <= a_i;
                        b_q     <= sub_i ? ~b_i : b_i;
                        carry_q <= sub_i ^ cin_i;
                        cnt_q   <= '0;
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    carry_q <= slice_cout;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_digit) begin
                        sum_q   <= res_d;
                        cout_q  <= slice_cout;
                        ovf_q   <= slice_cmsb ^ slice_cout;
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign sum_o      = sum_q;
    assign cout_o     = cout_q;
    assign overflow_o = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_somador_sequencial.sv
`default_nettype none
// ============================================================================
// Module   : tb_somador_sequencial
// Purpose  : Self-checking bench for somador_sequencial. Six instances with
//            different (WIDTH, DIGIT) share one stimulus stream; instance 0
//            (16,4) also receives directed handshake and reset scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_somador_sequencial;

    localparam int NI = 6;
    localparam int WW [NI] = '{16, 4, 8, 8, 32, 12};
    localparam int NN [NI] = '{ 4, 4, 1, 4,  8,  4};

    logic        clk;
    logic        rst;
    logic        start;
    logic        sub;
    logic        cin;
    logic [31:0] a;
    logic [31:0] b;

    logic [NI-1:0] by;
    logic [NI-1:0] dn;
    logic [NI-1:0] co;
    logic [NI-1:0] ov;
    logic [31:0]   sm [NI];

    logic [15:0] s0;
    logic [3:0]  s1;
    logic [7:0]  s2;
    logic [7:0]  s3;
    logic [31:0] s4;
    logic [11:0] s5;

    assign sm[0] = 32'(s0);
    assign sm[1] = 32'(s1);
    assign sm[2] = 32'(s2);
    assign sm[3] = 32'(s3);
    assign sm[4] = s4;
    assign sm[5] = 32'(s5);

    int checks   = 0;
    int failures = 0;

    // Per-instance results of the latest do_op
    logic [31:0] r_sum [NI];
    logic        r_co  [NI];
    logic        r_ov  [NI];

    somador_sequencial #(.WIDTH(16), .DIGIT(4)) u16 (
        .clock_i(clk), .reset_i(rst), .start_i(start), .sub_i(sub),
        .a_i(a[15:0]), .b_i(b[15:0]), .cin_i(cin),
        .busy_o(by[0]), .done_o(dn[0]), .sum_o(s0), .cout_o(co[0]), .overflow_o(ov[0]));
    somador_sequencial #(.WIDTH(4), .DIGIT(1)) u4 (
        .clock_i(clk), .reset_i(rst), .start_i(start), .sub_i(sub),
        .a_i(a[3:0]), .b_i(b[3:0]), .cin_i(cin),
        .busy_o(by[1]), .done_o(dn[1]), .sum_o(s1), .cout_o(co[1]), .overflow_o(ov[1]));
    somador_sequencial #(.WIDTH(8), .DIGIT(8)) u8a (
        .clock_i(clk), .reset_i(rst), .start_i(start), .sub_i(sub),
        .a_i(a[7:0]), .b_i(b[7:0]), .cin_i(cin),
        .busy_o(by[2]), .done_o(dn[2]), .sum_o(s2), .cout_o(co[2]), .overflow_o(ov[2]));
    somador_sequencial #(.WIDTH(8), .DIGIT(2)) u8b (
        .clock_i(clk), .reset_i(rst), .start_i(start), .sub_i(sub),
        .a_i(a[7:0]), .b_i(b[7:0]), .cin_i(cin),
        .busy_o(by[3]), .done_o(dn[3]), .sum_o(s3), .cout_o(co[3]), .overflow_o(ov[3]));
    somador_sequencial #(.WIDTH(32), .DIGIT(4)) u32 (
        .clock_i(clk), .reset_i(rst), .start_i(start), .sub_i(sub),
        .a_i(a), .b_i(b), .cin_i(cin),
        .busy_o(by[4]), .done_o(dn[4]), .sum_o(s4), .cout_o(co[4]), .overflow_o(ov[4]));
    somador_sequencial #(.WIDTH(12), .DIGIT(3)) u12 (
        .clock_i(clk), .reset_i(rst), .start_i(start), .sub_i(sub),
        .a_i(a[11:0]), .b_i(b[11:0]), .cin_i(cin),
        .busy_o(by[5]), .done_o(dn[5]), .sum_o(s5), .cout_o(co[5]), .overflow_o(ov[5]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} from plain integer arithmetic; overflow from
    // operand/result sign bits.
    function automatic logic [33:0] model(input int w, input logic [31:0] x,
                                          input logic [31:0] y, input logic ci,
                                          input logic s);
        logic [63:0] mask, xx, yy, r;
        logic        c, o;
        mask = (64'd1 << w) - 64'd1;
        xx   = {32'd0, x} & mask;
        yy   = (s ? ~{32'd0, y} : {32'd0, y}) & mask;
        r    = xx + yy + {63'd0, (s ? ~ci : ci)};
        c    = r[w];
        o    = (xx[w-1] == yy[w-1]) && (r[w-1] != xx[w-1]);
        r    = r & mask;
        return {o, c, r[31:0]};
    endfunction

    // One operation on all instances: start pulse, then watch every instance
    // for its done pulse, latency and result.
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv,
                         input logic ci, input logic s);
        int          first [NI];
        int          cnt   [NI];
        logic [33:0] exp;
        a = av; b = bv; cin = ci; sub = s; start = 1'b1;
        tick();
        start = 1'b0;
        // captured copies must be used from here on
        a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
        for (int k = 0; k < NI; k++) begin
            first[k] = 0;
            cnt[k]   = 0;
            check($sformatf("busy_after_start[%0d]", k), 64'(by[k]), 64'd1);
        end
        for (int t = 2; t <= 11; t++) begin
            tick();
            for (int k = 0; k < NI; k++) begin
                if (dn[k]) begin
                    cnt[k]++;
                    if (first[k] == 0) begin
                        first[k] = t;
                        r_sum[k] = sm[k];
                        r_co[k]  = co[k];
                        r_ov[k]  = ov[k];
                    end
                end
            end
        end
        for (int k = 0; k < NI; k++) begin
            exp = model(WW[k], av, bv, ci, s);
            check($sformatf("latency[%0d]", k), 64'(first[k]), 64'(NN[k] + 1));
            check($sformatf("done_count[%0d]", k), 64'(cnt[k]), 64'd1);
            check($sformatf("sum[%0d] a=%h b=%h", k, av, bv), 64'(r_sum[k]), 64'(exp[31:0]));
            check($sformatf("cout[%0d] a=%h b=%h", k, av, bv), 64'(r_co[k]), 64'(exp[32]));
            check($sformatf("ovf[%0d] a=%h b=%h", k, av, bv), 64'(r_ov[k]), 64'(exp[33]));
        end
    endtask

    task automatic check_zero16(input string tag);
        check({tag, "_busy"}, 64'(by[0]), 64'd0);
        check({tag, "_done"}, 64'(dn[0]), 64'd0);
        check({tag, "_sum"},  64'(s0),    64'd0);
        check({tag, "_cout"}, 64'(co[0]), 64'd0);
        check({tag, "_ovf"},  64'(ov[0]), 64'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        tick();
        tick();
        check_zero16("reset");
        rst = 1'b0;
        tick();
        check_zero16("idle");

        // 16-bit directed arithmetic
        do_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        check("add_ffff_sum", 64'(r_sum[0]), 64'h0000);
        check("add_ffff_cout", 64'(r_co[0]), 64'd1);
        check("add_ffff_ovf", 64'(r_ov[0]), 64'd0);
        do_op(32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0);
        check("add_7fff_sum", 64'(r_sum[0]), 64'h8000);
        check("add_7fff_cout", 64'(r_co[0]), 64'd0);
        check("add_7fff_ovf", 64'(r_ov[0]), 64'd1);
        do_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
        check("sub_5_7_sum", 64'(r_sum[0]), 64'hFFFE);
        check("sub_5_7_cout", 64'(r_co[0]), 64'd0);
        check("sub_5_7_ovf", 64'(r_ov[0]), 64'd0);
        do_op(32'h0000_8000, 32'h0000_0001, 1'b0, 1'b1);
        check("sub_8000_1_sum", 64'(r_sum[0]), 64'h7FFF);
        check("sub_8000_1_cout", 64'(r_co[0]), 64'd1);
        check("sub_8000_1_ovf", 64'(r_ov[0]), 64'd1);
        do_op(32'h0000_0010, 32'h0000_0010, 1'b1, 1'b1);
        check("sub_10_10_b_sum", 64'(r_sum[0]), 64'hFFFF);
        check("sub_10_10_b_cout", 64'(r_co[0]), 64'd0);

        // start held high: done every 5th cycle, never on adjacent cycles
        a = 32'h0000_0100; b = 32'h0000_0023; cin = 1'b0; sub = 1'b0; start = 1'b1;
        for (int t = 1; t <= 15; t++) begin
            tick();
            check($sformatf("held_done_t%0d", t), 64'(dn[0]), 64'((t % 5) == 0));
            check($sformatf("held_busy_t%0d", t), 64'(by[0]), 64'((t % 5) != 0));
            if (t % 5 == 0) begin
                check($sformatf("held_sum_t%0d", t), 64'(s0), 64'h0123);
            end
        end
        start = 1'b0;
        for (int t = 0; t < 11; t++) tick();

        // start pulse mid-RUN is ignored
        a = 32'h0000_1234; b = 32'h0000_1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        tick();
        tick();
        start = 1'b1; sub = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("midrun_done", 64'(dn[0]), 64'd1);
        check("midrun_sum", 64'(s0), 64'h2345);
        n = 0;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (dn[0]) n++;
        end
        check("midrun_no_second_done", 64'(n), 64'd0);
        check("midrun_sum_held", 64'(s0), 64'h2345);

        // asynchronous reset in the middle of RUN
        a = 32'h0000_00FF; b = 32'h0000_0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("prereset_busy", 64'(by[0]), 64'd1);
        rst = 1'b1;
        #1;
        check_zero16("async_reset");
        #1;
        rst = 1'b0;
        n = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (dn[0]) n++;
        end
        check("reset_no_done", 64'(n), 64'd0);
        do_op(32'h0000_1000, 32'h0000_0234, 1'b0, 1'b0);
        check("after_reset_sum", 64'(r_sum[0]), 64'h1234);

        // exhaustive 4-bit add (other instances see random upper bits)
        for (int i = 0; i < 512; i++) begin
            do_op(($urandom & 32'hFFFF_FFF0) | 32'(i & 15),
                  ($urandom & 32'hFFFF_FFF0) | 32'((i >> 4) & 15),
                  1'((i >> 8) & 1), 1'b0);
        end

        // random sweep, add and subtract
        for (int i = 0; i < 1000; i++) begin
            do_op($urandom, $urandom, 1'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/somador_sequencial.md
# somador_sequencial

Parametrised digit-serial adder/subtractor: adds or subtracts two WIDTH-bit operands DIGIT bits per clock, using a DIGIT-bit ripple-carry slice and a registered carry between digits. It generalises the combinational 4-bit ripple-carry adder to arbitrary width, adds a subtract mode, signed overflow detection and a start/done handshake. It serves as the shared arithmetic unit for multi-cycle datapaths where a full-width combinational adder is too large.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH. N = WIDTH/DIGIT digit cycles.
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a new operation; sampled on the rising edge of clock.
- sub  in  1  mode, sampled with start: 0 = a+b+cin, 1 = a−b−cin (cin acts as borrow-in).
- a  in  WIDTH  operand A, sampled with start.
- b  in  WIDTH  operand B, sampled with start.
- cin  in  1  carry-in (add) or borrow-in (sub), sampled with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse: result valid and newly updated.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB (sub: 1 = no borrow, 0 = borrow).
- overflow  out  1  two's-complement signed overflow of the operation.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE. On reset: busy=0, done=0, sum=0, cout=0, overflow=0, digit counter=0, internal registers cleared.
- IDLE/DONE with start=1: capture a, b_eff = sub ? ~b : b, carry = sub ? ~cin : cin, clear digit counter → RUN. start=0: DONE → IDLE, IDLE stays.
- RUN, each cycle: digit i = counter; {c_out, s_i} = a[i] + b_eff[i] + carry (DIGIT-bit ripple). s_i stored into internal result shift register; carry ← c_out; counter increments. start is ignored in RUN.
- After digit N−1: sum ← complete result; cout ← final carry; overflow ← carry into MSB XOR carry out of MSB (computed inside the last slice) → DONE.
- Equivalent arithmetic: add: {cout,sum} = a + b + cin; sub: {cout,sum} = a + ~b + ~cin (= a − b − cin + 2^WIDTH).
- sum/cout/overflow are registered and change only on transition into DONE. They hold between operations and during a subsequent RUN.
- busy = (state == RUN). done = (state == DONE).
- Back-to-back: start asserted during DONE begins the next operation immediately; done still pulses for exactly one cycle.
- Reset during RUN: operation aborted, no done pulse, all outputs return to reset values.
- Degenerate DIGIT=WIDTH: N=1, single RUN cycle.

## Timing
- Edge E0 samples start=1 (state IDLE or DONE) → RUN, busy=1 after E0.
- Edges E1…EN process digits 0…N−1; at EN the state becomes DONE and outputs update.
- done=1 and the result are valid during the cycle after EN. Latency from start edge to done = N+1 cycles (WIDTH=16, DIGIT=4: 5 cycles). busy is high for N cycles.
- Throughput: one operation per N+1 cycles with start held high.
- Operand inputs may change freely after E0; only captured copies are used.
- Reset is asynchronous: outputs clear immediately on reset rising, independent of clock.

## Test plan
- WIDTH=4, DIGIT=1, exhaustive: all 16×16 a,b × cin∈{0,1}, sub=0 → {cout,sum} == a+b+cin for all 512 cases; done after exactly 5 cycles each.
- WIDTH=16, DIGIT=4 add: 0xFFFF+0x0001, cin=0 → sum=0x0000, cout=1, overflow=0. 0x7FFF+0x0001 → sum=0x8000, cout=0, overflow=1. done exactly 5 cycles after start.
- Subtract: 0x0005−0x0007, cin=0 → sum=0xFFFE, cout=0, overflow=0. 0x8000−0x0001 → sum=0x7FFF, cout=1, overflow=1. 0x0010−0x0010, cin=1 → sum=0xFFFF, cout=0.
- Handshake: start held high continuously → done pulses once every 5 cycles, never two consecutive cycles. A start pulse in mid-RUN is ignored; the result of the first operation is unchanged.
- Reset mid-operation: assert reset at RUN cycle 2 → busy, done, sum, cout and overflow go to 0 immediately. No done follows. The next start completes normally.
- Parameter sweep: (WIDTH, DIGIT) = (8,8), (8,2), (32,4), (12,3) with 1000 random a, b, cin, sub → matches reference arithmetic; latency = WIDTH/DIGIT + 1.
